mem_access_ctrl: RTL and testbench

//  MEM-stage data-memory access controller, directly upstream of DataExtend.

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store per request over a req/ack word port.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned ops instead of force-aligning them.
`ifndef NOREGWRITE
`define NOREGWRITE 3'b000
`endif

module mem_access_ctrl #(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_load_type,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_addr_lo,
   output logic [2:0]  rsp_load_type,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             timeout;
   logic             trap;
   logic [1:0]       lo_al;
   logic [3:0]       be;
   logic [31:0]      wd_rep;

   logic [31:0]      op_addr, op_wdata, op_rdata;
   logic [3:0]       op_we;
   logic [1:0]       op_lo;
   logic [2:0]       op_type;
   logic             op_wr, op_err;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap  = ((req_size == 2'd1) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
   assign lo_al = req_addr[1:0];
`else
   // Misaligned ops are silently aligned down to their natural boundary.
   assign trap  = 1'b0;
   assign lo_al = req_size[1]          ? 2'b00 :
                  (req_size == 2'd1)   ? {req_addr[1], 1'b0} :
                                         req_addr[1:0];
`endif

   // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      be     = 4'b1111;
      wd_rep = req_wdata;
      case (req_size)
         2'd0: begin
            be     = 4'b0001 << lo_al;
            wd_rep = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            be     = 4'b0011 << {lo_al[1], 1'b0};
            wd_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cnt <= '0;
      else if (state == S_WAIT && !mem_ack) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
   end

   // NOTE: the op datapath has no reset; every output using it is gated by state.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req_valid) begin
         op_addr  <= {req_addr[31:2], 2'b00};
         op_we    <= req_wr ? be : 4'b0000;
         op_wdata <= wd_rep;
         op_lo    <= lo_al;
         op_type  <= req_wr ? `NOREGWRITE : req_load_type;
         op_wr    <= req_wr;
         op_err   <= trap;
         op_rdata <= '0;
      end else if (state == S_WAIT) begin
         if (mem_ack) begin
            if (!op_wr) op_rdata <= mem_rdata;
         end else if (timeout) begin
            op_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req_valid) state_nxt = trap ? S_RESP : S_WAIT;
         S_WAIT: if (mem_ack || timeout) state_nxt = S_RESP;
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall         = 1'b0;
      mem_req       = 1'b0;
      mem_addr      = '0;
      mem_we        = '0;
      mem_wdata     = '0;
      rsp_valid     = 1'b0;
      rsp_data      = '0;
      rsp_addr_lo   = '0;
      rsp_load_type = `NOREGWRITE;
      bus_err       = 1'b0;
      case (state)
         S_IDLE: stall = req_valid;
         S_WAIT: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = op_addr;
            mem_we    = op_we;
            mem_wdata = op_wdata;
         end
         S_RESP: begin
            rsp_valid     = 1'b1;
            rsp_data      = op_err ? 32'h0 : op_rdata;
            rsp_addr_lo   = op_lo;
            rsp_load_type = op_err ? `NOREGWRITE : op_type;
            bus_err       = op_err;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; a second instance with TIMEOUT_CYC=4 covers the timeout path.
// Expectations for the misaligned word case follow MEM_MISALIGN_TRAP_EN.
`ifndef NOREGWRITE
`define NOREGWRITE 3'b000
`endif
`ifndef LB
`define LB 3'b001
`endif
`ifndef LH
`define LH 3'b010
`endif
`ifndef LW
`define LW 3'b011
`endif

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_load_type = `NOREGWRITE;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0BAD0BAD;

   logic        a_stall, a_mem_req, a_rsp_valid, a_bus_err;
   logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_data;
   logic [3:0]  a_mem_we;
   logic [1:0]  a_rsp_addr_lo;
   logic [2:0]  a_rsp_load_type;

   logic        t_stall, t_mem_req, t_rsp_valid, t_bus_err;
   logic [31:0] t_mem_addr, t_mem_wdata, t_rsp_data;
   logic [3:0]  t_mem_we;
   logic [1:0]  t_rsp_addr_lo;
   logic [2:0]  t_rsp_load_type;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_load_type(req_load_type),
      .stall(a_stall), .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_we(a_mem_we),
      .mem_wdata(a_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_addr_lo(a_rsp_addr_lo),
      .rsp_load_type(a_rsp_load_type), .bus_err(a_bus_err)
   );

   mem_access_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut_t (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_load_type(req_load_type),
      .stall(t_stall), .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_we(t_mem_we),
      .mem_wdata(t_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_addr_lo(t_rsp_addr_lo),
      .rsp_load_type(t_rsp_load_type), .bus_err(t_bus_err)
   );

   // Observation mux: use_t selects the short-timeout instance.
   logic        use_t = 1'b0;
   logic        o_stall, o_mem_req, o_rsp_valid, o_bus_err;
   logic [31:0] o_mem_addr, o_mem_wdata, o_rsp_data;
   logic [3:0]  o_mem_we;
   logic [1:0]  o_rsp_addr_lo;
   logic [2:0]  o_rsp_load_type;
   assign o_stall         = use_t ? t_stall         : a_stall;
   assign o_mem_req       = use_t ? t_mem_req       : a_mem_req;
   assign o_rsp_valid     = use_t ? t_rsp_valid     : a_rsp_valid;
   assign o_bus_err       = use_t ? t_bus_err       : a_bus_err;
   assign o_mem_addr      = use_t ? t_mem_addr      : a_mem_addr;
   assign o_mem_wdata     = use_t ? t_mem_wdata     : a_mem_wdata;
   assign o_rsp_data      = use_t ? t_rsp_data      : a_rsp_data;
   assign o_mem_we        = use_t ? t_mem_we        : a_mem_we;
   assign o_rsp_addr_lo   = use_t ? t_rsp_addr_lo   : a_rsp_addr_lo;
   assign o_rsp_load_type = use_t ? t_rsp_load_type : a_rsp_load_type;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Results of the most recent run_op.
   int          req_cnt, rsp_cyc;
   logic        stall0, stall1, stable, r_stall, r_err;
   logic [31:0] f_addr, f_wdata, r_data;
   logic [3:0]  f_we;
   logic [1:0]  r_lo;
   logic [2:0]  r_type;

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Issues one op in cycle 0 and acks in cycle ack_at (0 = never); records what the DUT did.
   task automatic run_op(input string tag, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] lt,
                         input int ack_at, input logic [31:0] rdata);
      logic done = 1'b0;
      req_valid = 1'b1; req_wr = wr; req_size = size; req_addr = addr;
      req_wdata = wd; req_load_type = lt; mem_ack = 1'b0;
      #1 stall0 = o_stall;
      req_cnt = 0; rsp_cyc = -1; stable = 1'b1; stall1 = 1'b0;
      f_addr = '0; f_we = '0; f_wdata = '0;
      for (int cyc = 1; cyc < 40 && !done; cyc++) begin
         @(posedge clk); #1;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0BAD0BAD;
         if (cyc == 1) stall1 = o_stall;
         if (o_rsp_valid) begin
            rsp_cyc = cyc; r_data = o_rsp_data; r_lo = o_rsp_addr_lo;
            r_type = o_rsp_load_type; r_err = o_bus_err; r_stall = o_stall;
            req_valid = 1'b0;
            done = 1'b1;
         end else if (o_mem_req) begin
            if (req_cnt == 0) begin
               f_addr = o_mem_addr; f_we = o_mem_we; f_wdata = o_mem_wdata;
            end else if (o_mem_addr !== f_addr || o_mem_we !== f_we || o_mem_wdata !== f_wdata) begin
               stable = 1'b0;
            end
            req_cnt++;
            if (cyc == ack_at) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end
         end
      end
      check({tag, "_completed"}, 32'(done), 32'd1);
      req_valid = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic saw;
      rst_n = 1'b0;
      #1;
      check("rst_stall", 32'(a_stall), 0);
      check("rst_mem_req", 32'(a_mem_req), 0);
      check("rst_rsp_valid", 32'(a_rsp_valid), 0);
      check("rst_load_type", 32'(a_rsp_load_type), 32'(`NOREGWRITE));
      do_reset();

      run_op("lw", 1'b0, 2'd2, 32'h100, 32'h0, `LW, 1, 32'hDEADBEEF);
      check("lw_stall_c0", 32'(stall0), 1);
      check("lw_stall_c1", 32'(stall1), 1);
      check("lw_rsp_cycle", 32'(rsp_cyc), 2);
      check("lw_rsp_stall", 32'(r_stall), 0);
      check("lw_data", r_data, 32'hDEADBEEF);
      check("lw_lo", 32'(r_lo), 0);
      check("lw_type", 32'(r_type), 32'(`LW));
      check("lw_addr", f_addr, 32'h100);
      check("lw_we", 32'(f_we), 0);
      check("lw_err", 32'(r_err), 0);

      run_op("sb", 1'b1, 2'd0, 32'h203, 32'h000000A5, `LB, 1, 32'h11111111);
      check("sb_addr", f_addr, 32'h200);
      check("sb_we", 32'(f_we), 32'b1000);
      check("sb_wdata", f_wdata, 32'hA5A5A5A5);
      check("sb_type", 32'(r_type), 32'(`NOREGWRITE));
      check("sb_data", r_data, 0);

      run_op("sh", 1'b1, 2'd1, 32'h302, 32'h1234BEEF, `LH, 5, 32'h22222222);
      check("sh_we", 32'(f_we), 32'b1100);
      check("sh_wdata", f_wdata, 32'hBEEFBEEF);
      check("sh_req_cycles", 32'(req_cnt), 5);
      check("sh_stable", 32'(stable), 1);
      check("sh_rsp_cycle", 32'(rsp_cyc), 6);

      run_op("lb", 1'b0, 2'd0, 32'h101, 32'h0, `LB, 2, 32'h0A0B0C0D);
      check("lb_data", r_data, 32'h0A0B0C0D);
      check("lb_lo", 32'(r_lo), 1);
      check("lb_type", 32'(r_type), 32'(`LB));
      check("lb_rsp_cycle", 32'(rsp_cyc), 3);

      run_op("lw_mis", 1'b0, 2'd2, 32'h102, 32'h0, `LW, 1, 32'h33445566);
`ifdef MEM_MISALIGN_TRAP_EN
      check("mis_req_cycles", 32'(req_cnt), 0);
      check("mis_rsp_cycle", 32'(rsp_cyc), 1);
      check("mis_err", 32'(r_err), 1);
      check("mis_data", r_data, 0);
      check("mis_type", 32'(r_type), 32'(`NOREGWRITE));
`else
      check("mis_addr", f_addr, 32'h100);
      check("mis_rsp_cycle", 32'(rsp_cyc), 2);
      check("mis_err", 32'(r_err), 0);
      check("mis_data", r_data, 32'h33445566);
      check("mis_lo", 32'(r_lo), 0);
`endif

      // Stray ack while idle must be ignored.
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      saw = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (a_rsp_valid || a_mem_req || a_stall) saw = 1'b1;
      end
      mem_ack = 1'b0;
      check("idle_ack_ignored", 32'(saw), 0);

      do_reset();
      use_t = 1'b1;
      run_op("to", 1'b0, 2'd2, 32'h40, 32'h0, `LW, 0, 32'h0);
      check("to_req_cycles", 32'(req_cnt), 4);
      check("to_rsp_cycle", 32'(rsp_cyc), 5);
      check("to_err", 32'(r_err), 1);
      check("to_data", r_data, 0);
      check("to_type", 32'(r_type), 32'(`NOREGWRITE));
      check("to_stall", 32'(r_stall), 0);

      do_reset();
      run_op("to_ack", 1'b0, 2'd2, 32'h44, 32'h0, `LW, 4, 32'hCAFEF00D);
      check("to_ack_err", 32'(r_err), 0);
      check("to_ack_data", r_data, 32'hCAFEF00D);
      check("to_ack_rsp_cycle", 32'(rsp_cyc), 5);
      use_t = 1'b0;

      do_reset();
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_load_type = `LW;
      @(posedge clk); #1;
      check("rstw_in_wait", 32'(a_mem_req), 1);
      #2 rst_n = 1'b0; req_valid = 1'b0;
      #1;
      check("rstw_req_drop", 32'(a_mem_req), 0);
      check("rstw_stall_drop", 32'(a_stall), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      saw = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (a_rsp_valid) saw = 1'b1;
      end
      check("rstw_no_stale_rsp", 32'(saw), 0);
      run_op("post_rst", 1'b0, 2'd2, 32'h84, 32'h0, `LW, 1, 32'h5A5A1234);
      check("post_rst_cycle", 32'(rsp_cyc), 2);
      check("post_rst_data", r_data, 32'h5A5A1234);
      check("post_rst_err", 32'(r_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
